// File: rtl/xintf_bridge.sv
// XINTF-to-byte-stream bridge: TX FIFO (fabric -> DSP) and RX FIFO (DSP -> fabric)
// behind a synchronised XINTF slave port with status/control word and frame request.
`timescale 1ns/1ps
module xintf_bridge #(
    parameter int TX_AW       = 8,
    parameter int RX_AW       = 8,
    parameter int FRAME_LEN   = 22,
    parameter int TIMEOUT_CYC = 50000,
    parameter int PACK        = 0
) (
    input  logic             clk50M,
    input  logic             rst_n,
    input  logic             c_xcs_n,
    input  logic             xrd,
    input  logic             xwe,
    input  logic             xa0,
    inout  wire  [15:0]      xdata,
    output logic             c_xrd_req,
    input  logic             f1_wr_en,
    input  logic [7:0]       f1_buf_in,
    output logic             f1_full,
    output logic [TX_AW:0]   fifo1_cnt,
    input  logic             f2_rd_en,
    output logic [7:0]       f2_buf_out,
    output logic             f2_empty,
    output logic [RX_AW:0]   fifo2_cnt,
    output logic             tx_ovf,
    output logic             rx_ovf,
    output logic             tx_udf
);
    localparam int TXC  = TX_AW + 1;
    localparam int RXC  = RX_AW + 1;
    localparam int TO_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [TX_AW:0] TX_DEPTH = {1'b1, {TX_AW{1'b0}}};
    localparam logic [RX_AW:0] RX_DEPTH = {1'b1, {RX_AW{1'b0}}};

    // Synchroniser stages, bit order {a0, we, rd, cs}
    logic [3:0]       sync1_q, sync2_q;
    logic             rd_prev_q, we_prev_q;
    logic [15:0]      wdata_q, wdata_d;

    logic [TX_AW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [TX_AW:0]   tx_cnt_q, tx_cnt_d;
    logic             tx_full_q, tx_full_d;
    logic [RX_AW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [RX_AW:0]   rx_cnt_q, rx_cnt_d, rx_free;
    logic             rx_empty_q, rx_empty_d;
    logic             tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d, tx_udf_q, tx_udf_d;
    logic [TO_W-1:0]  idle_q, idle_d;
    logic             to_q, to_d, req_q, req_d;

    logic [7:0]       tx_mem [2**TX_AW];
    logic [7:0]       rx_mem [2**RX_AW];

    logic             cs_act, a0_s, rd_rise, we_rise;
    logic             data_rd, data_wr, ctl_wr, tx_flush, flag_clr;
    logic             tx_push, rx_pop;
    logic [1:0]       tx_pop_n, rx_in_n, rx_acc_n;
    logic [7:0]       tx_head0, tx_head1, cnt8;
    logic [15:0]      status_word, data_word;
    logic             bus_oe;

    // Edges are taken from the second sync stage against its delayed copy
    assign cs_act  = ~sync2_q[0];
    assign a0_s    = sync2_q[3];
    assign rd_rise = sync2_q[1] & ~rd_prev_q & cs_act;
    assign we_rise = sync2_q[2] & ~we_prev_q & cs_act;
    assign data_rd = rd_rise & ~a0_s;
    assign data_wr = we_rise & ~a0_s;
    assign ctl_wr  = we_rise & a0_s;

    // NOTE: every always_comb output is assigned a default first so no latch can be inferred.
    always_comb begin
        wdata_d   = sync2_q[2] ? wdata_q : xdata;
        tx_flush  = ctl_wr & wdata_q[1];
        flag_clr  = ctl_wr & wdata_q[0];

        tx_pop_n  = 2'd0;
        if (data_rd && tx_cnt_q != '0 && !tx_flush)
            tx_pop_n = (PACK != 0 && tx_cnt_q >= TXC'(2)) ? 2'd2 : 2'd1;
        // A pop or flush in the same cycle frees space, so a push into a full FIFO is accepted
        tx_push   = f1_wr_en & (~tx_full_q | (tx_pop_n != 2'd0) | tx_flush);
        tx_wptr_d = tx_wptr_q + TX_AW'(tx_push);
        tx_rptr_d = tx_rptr_q + TX_AW'(tx_pop_n);
        tx_cnt_d  = tx_cnt_q - TXC'(tx_pop_n) + TXC'(tx_push);
        if (tx_flush) begin
            tx_rptr_d = tx_wptr_q;
            tx_cnt_d  = TXC'(tx_push);
        end
        tx_full_d = (tx_cnt_d == TX_DEPTH);

        rx_in_n   = data_wr ? ((PACK != 0) ? 2'd2 : 2'd1) : 2'd0;
        rx_pop    = f2_rd_en & ~rx_empty_q;
        rx_free   = RX_DEPTH - rx_cnt_q + RXC'(rx_pop);
        rx_acc_n  = rx_in_n;
        if (rx_free == '0)
            rx_acc_n = 2'd0;
        else if (rx_free == RXC'(1) && rx_in_n == 2'd2)
            rx_acc_n = 2'd1;
        rx_wptr_d  = rx_wptr_q + RX_AW'(rx_acc_n);
        rx_rptr_d  = rx_rptr_q + RX_AW'(rx_pop);
        rx_cnt_d   = rx_cnt_q + RXC'(rx_acc_n) - RXC'(rx_pop);
        rx_empty_d = (rx_cnt_d == '0);

        tx_ovf_d = (tx_ovf_q & ~flag_clr) | (f1_wr_en & ~tx_push);
        rx_ovf_d = (rx_ovf_q & ~flag_clr) | (rx_acc_n != rx_in_n);
        tx_udf_d = (tx_udf_q & ~flag_clr) | (data_rd & (tx_cnt_q == '0));

        idle_d = idle_q;
        if (f1_wr_en || tx_cnt_q == '0)
            idle_d = '0;
        else if (idle_q != '1)
            idle_d = idle_q + TO_W'(1);

        to_d = to_q;
        if (tx_flush || tx_cnt_d == '0)
            to_d = 1'b0;
        else if (TIMEOUT_CYC != 0 && idle_q == TO_W'(TIMEOUT_CYC))
            to_d = 1'b1;
        req_d = (int'(tx_cnt_q) >= FRAME_LEN) | to_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 4'b0111;
            sync2_q    <= 4'b0111;
            rd_prev_q  <= 1'b1;
            we_prev_q  <= 1'b1;
            wdata_q    <= '0;
            tx_wptr_q  <= '0;
            tx_rptr_q  <= '0;
            tx_cnt_q   <= '0;
            tx_full_q  <= 1'b0;
            rx_wptr_q  <= '0;
            rx_rptr_q  <= '0;
            rx_cnt_q   <= '0;
            rx_empty_q <= 1'b1;
            tx_ovf_q   <= 1'b0;
            rx_ovf_q   <= 1'b0;
            tx_udf_q   <= 1'b0;
            idle_q     <= '0;
            to_q       <= 1'b0;
            req_q      <= 1'b0;
        end else begin
            sync1_q    <= {xa0, xwe, xrd, c_xcs_n};
            sync2_q    <= sync1_q;
            rd_prev_q  <= sync2_q[1];
            we_prev_q  <= sync2_q[2];
            wdata_q    <= wdata_d;
            tx_wptr_q  <= tx_wptr_d;
            tx_rptr_q  <= tx_rptr_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_full_q  <= tx_full_d;
            rx_wptr_q  <= rx_wptr_d;
            rx_rptr_q  <= rx_rptr_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_empty_q <= rx_empty_d;
            tx_ovf_q   <= tx_ovf_d;
            rx_ovf_q   <= rx_ovf_d;
            tx_udf_q   <= tx_udf_d;
            idle_q     <= idle_d;
            to_q       <= to_d;
            req_q      <= req_d;
        end
    end

    // NOTE: FIFO storage is not reset; the counts and empty/full flags guard every read of it.
    always_ff @(posedge clk50M) begin
        if (tx_push)
            tx_mem[tx_wptr_q] <= f1_buf_in;
        if (rx_acc_n != 2'd0)
            rx_mem[rx_wptr_q] <= wdata_q[7:0];
        if (rx_acc_n == 2'd2)
            rx_mem[rx_wptr_q + RX_AW'(1)] <= wdata_q[15:8];
    end

    assign tx_head0 = tx_mem[tx_rptr_q];
    assign tx_head1 = tx_mem[tx_rptr_q + TX_AW'(1)];

    always_comb begin
        cnt8        = (int'(tx_cnt_q) > 255) ? 8'hFF : 8'(tx_cnt_q);
        status_word = {tx_ovf_q, rx_ovf_q, tx_udf_q, req_q, 4'b0000, cnt8};
        data_word   = {8'h00, tx_head0};
        if (tx_cnt_q == '0)
            data_word = 16'h0000;
        else if (PACK != 0 && tx_cnt_q >= TXC'(2))
            data_word = {tx_head1, tx_head0};
    end

    // Read data is driven straight from the raw pins so it is valid for the whole strobe
    assign bus_oe = rst_n & ~c_xcs_n & ~xrd;
    assign xdata  = bus_oe ? (xa0 ? status_word : data_word) : 16'hzzzz;

    assign c_xrd_req  = req_q;
    assign f1_full    = tx_full_q;
    assign fifo1_cnt  = tx_cnt_q;
    assign f2_buf_out = rx_empty_q ? 8'h00 : rx_mem[rx_rptr_q];
    assign f2_empty   = rx_empty_q;
    assign fifo2_cnt  = rx_cnt_q;
    assign tx_ovf     = tx_ovf_q;
    assign rx_ovf     = rx_ovf_q;
    assign tx_udf     = tx_udf_q;
endmodule

// File: tb/tb_xintf_bridge.sv
// Directed bench: an unpacked instance and a packed instance share the DSP bus
// (separate chip selects); expected values are hand-computed constants.
`timescale 1ns/1ps
module tb_xintf_bridge;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs0_n = 1'b1, cs1_n = 1'b1, xrd = 1'b1, xwe = 1'b1, xa0 = 1'b0;
    logic        tb_oe = 1'b0;
    logic [15:0] tb_wdata = '0;
    wire  [15:0] xdata;
    assign xdata = tb_oe ? tb_wdata : 16'hzzzz;

    logic       req0, wr0 = 1'b0, full0, rd0 = 1'b0, empty0, txo0, rxo0, udf0;
    logic [7:0] in0 = '0, out0;
    logic [8:0] cnt1_0, cnt2_0;
    logic       req1, wr1 = 1'b0, full1, rd1 = 1'b0, empty1, txo1, rxo1, udf1;
    logic [7:0] in1 = '0, out1;
    logic [4:0] cnt1_1, cnt2_1;

    xintf_bridge #(.TX_AW(8), .RX_AW(8), .FRAME_LEN(22), .TIMEOUT_CYC(100), .PACK(0)) u_dut (
        .clk50M(clk), .rst_n(rst_n), .c_xcs_n(cs0_n), .xrd(xrd), .xwe(xwe), .xa0(xa0),
        .xdata(xdata), .c_xrd_req(req0), .f1_wr_en(wr0), .f1_buf_in(in0), .f1_full(full0),
        .fifo1_cnt(cnt1_0), .f2_rd_en(rd0), .f2_buf_out(out0), .f2_empty(empty0),
        .fifo2_cnt(cnt2_0), .tx_ovf(txo0), .rx_ovf(rxo0), .tx_udf(udf0));

    xintf_bridge #(.TX_AW(4), .RX_AW(4), .FRAME_LEN(4), .TIMEOUT_CYC(0), .PACK(1)) u_dut_p (
        .clk50M(clk), .rst_n(rst_n), .c_xcs_n(cs1_n), .xrd(xrd), .xwe(xwe), .xa0(xa0),
        .xdata(xdata), .c_xrd_req(req1), .f1_wr_en(wr1), .f1_buf_in(in1), .f1_full(full1),
        .fifo1_cnt(cnt1_1), .f2_rd_en(rd1), .f2_buf_out(out1), .f2_empty(empty1),
        .fifo2_cnt(cnt2_1), .tx_ovf(txo1), .rx_ovf(rxo1), .tx_udf(udf1));

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sel_cs(input logic sel, input logic val);
        if (sel) cs1_n = val;
        else     cs0_n = val;
    endtask

    task automatic bus_read(input logic sel, input logic a0, output logic [15:0] data);
        xa0 = a0;
        sel_cs(sel, 1'b0);
        xrd = 1'b0;
        tick(4);
        data = xdata;
        xrd = 1'b1;
        tick(4);
        sel_cs(sel, 1'b1);
    endtask

    task automatic bus_write(input logic sel, input logic a0, input logic [15:0] data);
        xa0 = a0;
        sel_cs(sel, 1'b0);
        tb_wdata = data;
        tb_oe = 1'b1;
        xwe = 1'b0;
        tick(4);
        xwe = 1'b1;
        tick(4);
        tb_oe = 1'b0;
        sel_cs(sel, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] rd;
        int waited;

        // Reset values on both instances
        tick(3);
        check("rst_req0", req0, 0);
        check("rst_full0", full0, 0);
        check("rst_cnt1_0", cnt1_0, 0);
        check("rst_empty0", empty0, 1);
        check("rst_cnt2_0", cnt2_0, 0);
        check("rst_out0", out0, 0);
        check("rst_flags0", {txo0, rxo0, udf0}, 0);
        check("rst_p", {req1, full1, empty1, txo1, rxo1, udf1}, 6'b001000);
        check("rst_p_cnt", {cnt1_1, cnt2_1, out1}, 0);
        rst_n = 1'b1;
        tick(2);

        // Frame request: 22 bytes raise c_xrd_req one cycle after the count
        for (int i = 0; i < 22; i++) begin
            wr0 = 1'b1;
            in0 = 8'(i);
            tick(1);
        end
        wr0 = 1'b0;
        check("frame_cnt22", cnt1_0, 22);
        check("frame_req_lag", req0, 0);
        tick(1);
        check("frame_req", req0, 1);
        bus_read(0, 0, rd);
        check("frame_rd0", rd, 16'h0000);
        check("frame_cnt21", cnt1_0, 21);
        check("frame_req_drop", req0, 0);
        for (int i = 1; i < 22; i++) begin
            bus_read(0, 0, rd);
            check("frame_rd", rd, 32'(i));
        end
        check("frame_cnt0", cnt1_0, 0);
        check("frame_req_empty", req0, 0);
        check("frame_udf_pre", udf0, 0);
        bus_read(0, 0, rd);
        check("udf_data", rd, 16'h0000);
        check("udf_flag", udf0, 1);
        check("udf_cnt", cnt1_0, 0);
        bus_write(0, 1, 16'h0001);
        check("udf_clear", udf0, 0);

        // Timeout request on a 3-byte partial frame
        for (int i = 0; i < 3; i++) begin
            wr0 = 1'b1;
            in0 = 8'(8'h31 + i);
            tick(1);
        end
        wr0 = 1'b0;
        tick(98);
        check("to_early", req0, 0);
        waited = 0;
        while (req0 !== 1'b1 && waited < 20) begin
            tick(1);
            waited++;
        end
        check("to_rise", req0, 1);
        check("to_window", 32'(waited >= 1 && waited <= 6), 1);
        for (int i = 0; i < 3; i++) begin
            bus_read(0, 0, rd);
            check("to_rd", rd, 32'(8'h31 + i));
        end
        check("to_cnt0", cnt1_0, 0);
        check("to_req0", req0, 0);

        // Overflow on both FIFOs, status word, flag clear
        for (int i = 0; i < 256; i++) begin
            wr0 = 1'b1;
            in0 = 8'(i + 16);
            tick(1);
        end
        wr0 = 1'b0;
        check("ovf_cnt_full", cnt1_0, 256);
        check("ovf_full", full0, 1);
        check("ovf_tx_pre", txo0, 0);
        wr0 = 1'b1;
        in0 = 8'hEE;
        tick(1);
        wr0 = 1'b0;
        check("ovf_tx", txo0, 1);
        check("ovf_tx_cnt", cnt1_0, 256);
        for (int j = 0; j < 256; j++)
            bus_write(0, 0, {8'hAB, 8'(j)});
        check("ovf_rx_cnt", cnt2_0, 256);
        check("ovf_rx_pre", rxo0, 0);
        check("ovf_rx_head", out0, 8'h00);
        check("ovf_rx_nonempty", empty0, 0);
        bus_write(0, 0, 16'hABFF);
        check("ovf_rx", rxo0, 1);
        check("ovf_rx_cnt2", cnt2_0, 256);
        bus_read(0, 1, rd);
        check("status_word", rd, 16'hD0FF);
        check("status_nopop", cnt1_0, 256);
        bus_write(0, 1, 16'h0001);
        check("clr_flags", {txo0, rxo0, udf0}, 0);

        // Simultaneous push and pop while TX is full (pop lands 3 edges after xrd rises)
        cs0_n = 1'b0;
        xa0 = 1'b0;
        xrd = 1'b0;
        tick(4);
        rd = xdata;
        check("sim_head", rd, 16'h0010);
        xrd = 1'b1;
        tick(2);
        wr0 = 1'b1;
        in0 = 8'h77;
        tick(1);
        wr0 = 1'b0;
        check("sim_cnt", cnt1_0, 256);
        check("sim_no_ovf", txo0, 0);
        check("sim_full", full0, 1);
        tick(1);
        cs0_n = 1'b1;
        for (int i = 1; i < 256; i++) begin
            bus_read(0, 0, rd);
            check("sim_order", rd, 32'((i + 16) & 255));
        end
        bus_read(0, 0, rd);
        check("sim_last", rd, 16'h0077);
        check("sim_cnt0", cnt1_0, 0);

        // TX flush via control bit 1
        for (int i = 0; i < 30; i++) begin
            wr0 = 1'b1;
            in0 = 8'(i);
            tick(1);
        end
        wr0 = 1'b0;
        tick(2);
        check("flush_pre_cnt", cnt1_0, 30);
        check("flush_pre_req", req0, 1);
        bus_write(0, 1, 16'h0002);
        check("flush_cnt", cnt1_0, 0);
        check("flush_req", req0, 0);
        check("flush_full", full0, 0);

        // RX pop: next byte visible one cycle later
        rd0 = 1'b1;
        tick(1);
        rd0 = 1'b0;
        check("rx_pop_head", out0, 8'h01);
        check("rx_pop_cnt", cnt2_0, 255);

        // Packed instance: two bytes per word, low byte first
        for (int i = 0; i < 3; i++) begin
            wr1 = 1'b1;
            in1 = 8'(8'hA1 + 8'h11 * i);
            tick(1);
        end
        wr1 = 1'b0;
        tick(1);
        check("pk_cnt3", cnt1_1, 3);
        check("pk_req", req1, 0);
        bus_read(1, 0, rd);
        check("pk_rd0", rd, 16'hB2A1);
        check("pk_cnt1", cnt1_1, 1);
        bus_read(1, 0, rd);
        check("pk_rd1", rd, 16'h00C3);
        check("pk_cnt0", cnt1_1, 0);
        bus_write(1, 0, 16'h5678);
        check("pk_wr_cnt", cnt2_1, 2);
        check("pk_wr_lo", out1, 8'h78);
        rd1 = 1'b1;
        tick(1);
        rd1 = 1'b0;
        check("pk_wr_hi", out1, 8'h56);
        for (int k = 0; k < 7; k++)
            bus_write(1, 0, {8'(2 * k + 1), 8'(2 * k)});
        check("pk_rx15", cnt2_1, 15);
        check("pk_ovf_pre", rxo1, 0);
        bus_write(1, 0, 16'h9A9B);
        check("pk_rx16", cnt2_1, 16);
        check("pk_ovf", rxo1, 1);
        check("pk_head", out1, 8'h56);
        check("pk_tx_flags", {full1, txo1, udf1}, 0);

        // Reset while xwe is held low: nothing commits, bus stays released
        cs0_n = 1'b0;
        xa0 = 1'b0;
        tb_wdata = 16'h1234;
        tb_oe = 1'b1;
        xwe = 1'b0;
        tick(4);
        rst_n = 1'b0;
        #1;
        check("mid_rst_cnt2", cnt2_0, 0);
        check("mid_rst_empty", empty0, 1);
        xrd = 1'b0;
        tb_wdata = 16'h3C3C;
        #1;
        check("mid_rst_bus", xdata, 16'h3C3C);
        tick(2);
        xrd = 1'b1;
        xwe = 1'b1;
        tb_oe = 1'b0;
        cs0_n = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(6);
        check("post_rst_cnt2", cnt2_0, 0);
        check("post_rst_empty", empty0, 1);
        check("post_rst_out", out0, 0);
        check("post_rst_tx", {req0, full0, cnt1_0}, 0);
        check("post_rst_flags", {txo0, rxo0, udf0}, 0);
        check("post_rst_p", {cnt2_1, rxo1, empty1}, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/xintf_bridge.md
# xintf_bridge

Parametrised XINTF-to-byte-stream bridge joining the DSP external bus to the FPGA's byte-oriented paths (UART and similar). It contains two FIFOs: TX (fabric to DSP) and RX (DSP to fabric), with configurable depths. It generalises the fixed 22-byte, 8-bit bridge with:
- a configurable frame threshold;
- an idle-timeout partial-frame request;
- optional 2-bytes-per-word packing;
- an XINTF-addressable status/control word;
- sticky overflow/underflow flags.

## Interface
Parameters:
- TX_AW, 8: log2 of TX FIFO depth in bytes.
- RX_AW, 8: log2 of RX FIFO depth in bytes.
- FRAME_LEN, 22: TX byte count that raises c_xrd_req; range 1..2^TX_AW.
- TIMEOUT_CYC, 50000: idle clocks before a partial TX frame raises c_xrd_req; 0 disables.
- PACK, 0: 0 = one byte per XINTF word (high byte 0); 1 = two bytes per word, low byte first.

Ports (one clock; reset is asynchronous, active-low):
- clk50M  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- c_xcs_n  in  1  XINTF chip select, active low
- xrd  in  1  XINTF read strobe, active low
- xwe  in  1  XINTF write strobe, active low
- xa0  in  1  address: 0 = data, 1 = status/control
- xdata  inout  16  XINTF data
- c_xrd_req  out  1  request to the DSP to read TX
- f1_wr_en  in  1  push f1_buf_in into TX
- f1_buf_in  in  8  TX write byte
- f1_full  out  1  TX full
- fifo1_cnt  out  TX_AW+1  TX bytes held
- f2_rd_en  in  1  pop RX
- f2_buf_out  out  8  RX head byte (first-word fall-through)
- f2_empty  out  1  RX empty
- fifo2_cnt  out  RX_AW+1  RX bytes held
- tx_ovf  out  1  sticky: TX push dropped
- rx_ovf  out  1  sticky: RX push dropped
- tx_udf  out  1  sticky: data read while TX empty

## Operation
- **Synchronisers.** c_xcs_n, xrd, xwe and xa0 pass through 2-FF synchronisers. A strobe edge counts only if synchronised c_xcs_n is low at that edge.
- **Bus drive.**
  - xdata is driven when raw c_xcs_n, xrd and xa0-decode permit; the enable is pure combinational on the raw pins (!c_xcs_n & !xrd).
  - Otherwise xdata is high-Z.
- **Data read (xa0=0).**
  - PACK=0: xdata = {8'h00, TX head}.
  - PACK=1: xdata = {TX head+1, TX head}. When only one byte is held, the high byte is 8'h00.
  - The pop happens on the synchronised rising edge of xrd: 1 byte (PACK=0), or min(2, count) bytes (PACK=1).
  - If TX is empty, xdata = 16'h0000, nothing pops and tx_udf is set.
- **Status read (xa0=1).** xdata = {tx_ovf, rx_ovf, tx_udf, c_xrd_req, 4'b0, fifo1_cnt[7:0]} when TX_AW ≤ 7; otherwise fifo1_cnt saturates at 255. A status read never pops.
- **Data write (xa0=0).**
  - xdata is sampled every clock while synchronised xwe is low.
  - On the synchronised xwe rising edge the last sample is committed: byte [7:0] (PACK=0), or [7:0] then [15:8] (PACK=1).
  - Each byte that finds RX full is dropped and sets rx_ovf. For PACK=1 with one free slot, the low byte is stored and the high byte dropped.
- **Control write (xa0=1).**
  - bit0 = 1: clear all three sticky flags.
  - bit1 = 1: flush TX (count to 0, pointers equal).
  - Other bits are ignored.
- **TX push.** f1_wr_en when full: byte dropped, tx_ovf set.
- **RX pop.** f2_rd_en when empty: ignored.
- **Simultaneous push and pop** on one FIFO in the same cycle: both occur and the count is unchanged. This includes the full case, which is accepted because space frees that cycle.
- **Request logic.**
  - c_xrd_req = (fifo1_cnt ≥ FRAME_LEN) | to_flag.
  - An idle counter resets on any f1_wr_en or when TX is empty, and otherwise increments, saturating.
  - to_flag sets when the counter reaches TIMEOUT_CYC with TX non-empty.
  - to_flag clears when TX becomes empty or on a TX flush.
- **Pointers.** Pointers wrap modulo 2^AW; the count is held in a separate (AW+1)-bit register.

## Timing
- **Reset values.** All outputs are 0 except f2_empty = 1; xdata is high-Z; FIFOs are empty; the idle counter is 0. Reset mid-transaction aborts it with no partial commit.
- **DSP strobe latency.** An xrd/xwe pin edge takes effect 3 clk50M cycles later (2 sync + 1 edge detect). The DSP strobe width must be ≥ 4 clocks (80 ns).
- **Fabric-side latency.**
  - f1_wr_en: fifo1_cnt updates 1 cycle later; c_xrd_req follows 1 cycle after that.
  - f2_rd_en: f2_buf_out shows the next byte 1 cycle later.
- **FIFO status signals.** f1_full and f2_empty are registered and update with the counts.
- **Bus data validity.** Data read via xdata reflects the registered FIFO head, stable while xrd is low. The head is updated only by the pop after xrd rises.

## Test plan
- **Frame request.** PACK=0, FRAME_LEN=22: push 0x00..0x15 -> c_xrd_req=1 two cycles after the 22nd push; 22 XINTF reads return 0x0000..0x0015; c_xrd_req drops when fifo1_cnt < 22; the 23rd read returns 0x0000 with tx_udf=1.
- **Timeout request.** TIMEOUT_CYC=100: push 3 bytes, then idle -> c_xrd_req rises after the 3rd push plus 100 cycles; after 3 reads TX is empty and c_xrd_req=0.
- **Packed read and write.** PACK=1: push 0xA1,0xB2,0xC3 -> reads return 0xB2A1 then 0x00C3; XINTF write 0x5678 -> f2_buf_out shows 0x78, then 0x56 after one f2_rd_en.
- **Overflow and clear.**
  - Fill TX to 256, then push 0xEE -> tx_ovf=1, fifo1_cnt=256.
  - Fill RX to 256, then one more XINTF write -> rx_ovf=1.
  - Status read shows bits 15 and 14 set.
  - Control write 0x0001 clears both flags.
- **Simultaneous full push/pop.** TX full, f1_wr_en in the same cycle as an XINTF pop -> count stays 256 and the pushed byte is read last. Control write 0x0002 -> fifo1_cnt=0 and c_xrd_req=0.
- **Reset mid-operation.** rst_n low while xwe is held low -> no RX commit, xdata high-Z, all outputs at their reset values.
